// File: rtl/frame_rx_pkg.sv
// frame_rx_pkg: shared state encoding, framing defaults and checksum width for frame_rx
package frame_rx_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHK     = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [7:0] SOF_DEFAULT     = 8'hA5;
  localparam int         MAX_LEN_DEFAULT = 16;
  localparam int         TIMEOUT_DEFAULT = 255;
  localparam int         CHK_W           = 8;
  function automatic int addr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/frame_buf.sv
// frame_buf: payload register file with a synchronous write port and a registered read port
module frame_buf
  import frame_rx_pkg::*;
#(
  parameter int DEPTH = MAX_LEN_DEFAULT,
  parameter int AW    = addr_w(DEPTH),
  parameter int DW    = CHK_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  // storage is never reset; stale bytes are never read back
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  // read register holds its value between strobes so downstream data stays stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/frame_rx.sv
// frame_rx: SOF hunt, length-prefixed capture, checksum check and bubble-free drain (option: FRAME_TIMEOUT_EN)
module frame_rx
  import frame_rx_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
  parameter int         MAX_LEN        = MAX_LEN_DEFAULT,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       frame_done,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_ovr,
  output logic       err_timeout,
  output logic       busy
);
  localparam int            IW    = $clog2(MAX_LEN + 1);
  localparam int            AW    = addr_w(MAX_LEN);
  localparam logic [7:0]    MAX_B = 8'(MAX_LEN);
  localparam logic [IW-1:0] ONE   = IW'(1);
  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    len_q, len_d, wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, wr_nxt, rd_nxt;
  logic [CHK_W-1:0] sum_q, sum_d;
  logic             valid_q, valid_d, done_q, done_d;
  logic             err_len_q, err_len_d, err_chk_q, err_chk_d, err_ovr_q, err_ovr_d;
  logic             we, re, to_hit;
  logic [AW-1:0]    raddr;
  assign wr_nxt = wr_idx_q + ONE;
  assign rd_nxt = rd_idx_q + ONE;
  // read address runs one byte ahead of the byte on data_out so the drain has no bubble
  assign raddr  = state_q == S_DRAIN ? rd_nxt[AW-1:0] : '0;
  frame_buf #(.DEPTH(MAX_LEN), .AW(AW), .DW(8)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we),
    .waddr_i (wr_idx_q[AW-1:0]),
    .wdata_i (in_data),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (data_out)
  );
  // frame state machine: next state, indices, running sum and registered pulses
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    sum_d     = sum_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    err_len_d = 1'b0;
    err_chk_d = 1'b0;
    err_ovr_d = 1'b0;
    we        = 1'b0;
    re        = 1'b0;
    case (state_q)
      S_IDLE: state_d = (in_valid && in_data == SOF_BYTE) ? S_LEN : S_IDLE;
      S_LEN: if (in_valid) begin
        sum_d     = in_data;
        len_d     = in_data[IW-1:0];
        wr_idx_d  = '0;
        err_len_d = in_data == 8'd0 || in_data > MAX_B;
        state_d   = err_len_d ? S_IDLE : S_PAYLOAD;
      end
      S_PAYLOAD: if (in_valid) begin
        we       = 1'b1;
        sum_d    = sum_q + in_data;
        wr_idx_d = wr_nxt;
        state_d  = wr_nxt == len_q ? S_CHK : S_PAYLOAD;
      end
      S_CHK: if (in_valid) begin
        re        = in_data == sum_q;
        valid_d   = re;
        done_d    = re && len_q == ONE;
        rd_idx_d  = '0;
        err_chk_d = !re;
        state_d   = re ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        err_ovr_d = in_valid;
        re        = rd_nxt != len_q;
        valid_d   = re;
        done_d    = re && rd_nxt + ONE == len_q;
        rd_idx_d  = re ? rd_nxt : rd_idx_q;
        state_d   = re ? S_DRAIN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (to_hit) state_d = S_IDLE;
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      sum_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_len_q <= 1'b0;
      err_chk_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      sum_q     <= sum_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_len_q <= err_len_d;
      err_chk_q <= err_chk_d;
      err_ovr_q <= err_ovr_d;
    end
  end
`ifdef FRAME_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_q;
  logic          err_to_q, mid;
  assign mid    = state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CHK;
  assign to_hit = mid && !in_valid && to_q == TO_LAST;
  // counts consecutive starved cycles mid-frame; an accepted byte or leaving the frame clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q     <= '0;
      err_to_q <= 1'b0;
    end else begin
      to_q     <= (mid && !in_valid && !to_hit) ? to_q + TW'(1) : '0;
      err_to_q <= to_hit;
    end
  end
  assign err_timeout = err_to_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign to_hit         = 1'b0;
  assign err_timeout    = 1'b0;
`endif
  assign valid_out  = valid_q;
  assign frame_done = done_q;
  assign err_len    = err_len_q;
  assign err_chk    = err_chk_q;
  assign err_ovr    = err_ovr_q;
  assign busy       = state_q != S_IDLE;
endmodule
